// File: rtl/event_led_pkg.sv
// Shared types and widths for the launchpad front-panel event-to-LED engine.
// Imported by the arbiter and the top level so both agree on counter widths.
package event_led_pkg;

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'd0,
        MODE_PULSE  = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_RSVD   = 2'd3
    } led_mode_e;

    localparam int COL_W  = 3;
    localparam int DROP_W = 8;

    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    // Index width that stays legal (>=1) even for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/event_arbiter.sv
// Edge detection, pending queue with fixed-priority grant (index 0 highest)
// and saturating count of events that arrive while their slot is still pending.
module event_arbiter
    import event_led_pkg::*;
#(
    parameter int N_EV  = 13,
    parameter int IDX_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_EV-1:0]   events,
    output logic              grant_valid,
    output logic [IDX_W-1:0]  grant_idx,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              busy
);

    localparam int CNT_W = $clog2(N_EV + 1);
    localparam int SUM_W = DROP_W + CNT_W;

    logic [N_EV-1:0]  event_q;
    logic [N_EV-1:0]  pend;
    logic [N_EV-1:0]  pend_next;
    logic [N_EV-1:0]  rise;
    logic [N_EV-1:0]  grant_oh;
    logic [N_EV-1:0]  drop_hit;
    logic [CNT_W-1:0] drop_num;
    logic [SUM_W-1:0] drop_sum;
    logic             clear_grant;

    assign rise        = events & ~event_q;
    assign grant_oh    = pend & (~pend + N_EV'(1));
    assign grant_valid = |pend;
    assign busy        = |pend;
    assign clear_grant = grant_oh[N_EV-1];
    assign drop_hit    = rise & pend & ~grant_oh;

    always_comb begin
        grant_idx = '0;
        for (int i = N_EV - 1; i >= 0; i--) begin
            if (pend[i]) grant_idx = IDX_W'(i);
        end
    end

    // Several slots can overflow in one cycle; each one counts as its own drop.
    always_comb begin
        drop_num = '0;
        for (int i = 0; i < N_EV; i++) begin
            drop_num = drop_num + CNT_W'(drop_hit[i]);
        end
    end

    assign drop_sum = SUM_W'(drop_cnt) + SUM_W'(drop_num);

    // A granted clear flushes the queue, but rises arriving alongside it survive.
    assign pend_next = clear_grant ? rise : ((pend & ~grant_oh) | rise);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            event_q  <= '0;
            pend     <= '0;
            drop_cnt <= '0;
        end else begin
            event_q  <= events;
            pend     <= pend_next;
            drop_cnt <= (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_W-1:0];
        end
    end

endmodule

// File: rtl/event_led_engine.sv
// Event-to-indicator engine: one arbitrated event path driving mono LEDs
// (toggle/pulse/blink) and RGB colour steppers, plus a global clear event.
module event_led_engine
    import event_led_pkg::*;
#(
    parameter int N_LED        = 8,
    parameter int N_RGB        = 4,
    parameter int PULSE_CYCLES = 5,
    parameter int BLINK_HALF   = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_LED+N_RGB:0]   events,
    input  logic [1:0]             mode,
    output logic [N_LED-1:0]       led,
    output logic [N_RGB-1:0]       rgb_r,
    output logic [N_RGB-1:0]       rgb_g,
    output logic [N_RGB-1:0]       rgb_b,
    output logic [DROP_W-1:0]      drop_cnt,
    output logic                   busy
);

    localparam int N_EV   = N_LED + N_RGB + 1;
    localparam int IDX_W  = idx_width(N_EV);
    localparam int PCNT_W = $clog2(PULSE_CYCLES + 1);
    localparam int PRE_W  = idx_width(BLINK_HALF);

    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic [N_EV-1:0]   dispatch_oh;
    logic [N_LED-1:0]  led_hit;
    logic [N_RGB-1:0]  rgb_hit;
    logic              clear_hit;

    logic [N_LED-1:0]  tog;
    logic [N_LED-1:0]  ben;
    logic [PCNT_W-1:0] pcnt [N_LED];
    logic [COL_W-1:0]  col  [N_RGB];
    logic [PRE_W-1:0]  prescale;
    logic              phase;
    led_mode_e         live_mode;

    assign live_mode = led_mode_e'(mode);

    event_arbiter #(
        .N_EV  (N_EV),
        .IDX_W (IDX_W)
    ) u_arbiter (
        .CLK         (CLK),
        .RST         (RST),
        .events      (events),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .drop_cnt    (drop_cnt),
        .busy        (busy)
    );

    always_comb begin
        dispatch_oh = '0;
        for (int i = 0; i < N_EV; i++) begin
            dispatch_oh[i] = grant_valid && (grant_idx == IDX_W'(i));
        end
    end

    assign led_hit   = dispatch_oh[N_LED-1:0];
    assign rgb_hit   = dispatch_oh[N_EV-2:N_LED];
    assign clear_hit = dispatch_oh[N_EV-1];

    // Mode is sampled at dispatch; each mode keeps its own state so switching
    // modes later shows whatever that mode last held.
    always_ff @(posedge CLK) begin
        if (!RST || clear_hit) begin
            tog <= '0;
            ben <= '0;
            for (int c = 0; c < N_LED; c++) pcnt[c] <= '0;
        end else begin
            for (int c = 0; c < N_LED; c++) begin
                if (led_hit[c] && live_mode == MODE_PULSE)
                    pcnt[c] <= PCNT_W'(PULSE_CYCLES);
                else if (pcnt[c] != '0)
                    pcnt[c] <= pcnt[c] - PCNT_W'(1);
                if (led_hit[c] && live_mode == MODE_BLINK)
                    ben[c] <= ~ben[c];
                if (led_hit[c] && (live_mode == MODE_TOGGLE || live_mode == MODE_RSVD))
                    tog[c] <= ~tog[c];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST || clear_hit) begin
            for (int c = 0; c < N_RGB; c++) col[c] <= '0;
        end else begin
            for (int c = 0; c < N_RGB; c++) begin
                if (rgb_hit[c]) col[c] <= col[c] + COL_W'(1);
            end
        end
    end

    // Shared blink timebase; deliberately left running through a clear.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            prescale <= '0;
            phase    <= 1'b0;
        end else if (prescale == PRE_W'(BLINK_HALF - 1)) begin
            prescale <= '0;
            phase    <= ~phase;
        end else begin
            prescale <= prescale + PRE_W'(1);
        end
    end

    always_comb begin
        led   = '0;
        rgb_r = '0;
        rgb_g = '0;
        rgb_b = '0;
        for (int c = 0; c < N_LED; c++) begin
            case (live_mode)
                MODE_PULSE: led[c] = (pcnt[c] != '0);
                MODE_BLINK: led[c] = ben[c] & phase;
                default:    led[c] = tog[c];
            endcase
        end
        for (int c = 0; c < N_RGB; c++) begin
            rgb_r[c] = col[c][2];
            rgb_g[c] = col[c][1];
            rgb_b[c] = col[c][0];
        end
    end

endmodule
